// File: rtl/irq_pkg.sv
// irq_pkg: shared types, widths and helpers for the vectored interrupt controller
package irq_pkg;
  localparam int VEC_W = 16;
  localparam int MAX_CH = 16;
  typedef enum logic [1:0] {IDLE, SEL, ACK, WAIT} irq_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: NCH-input priority encoder searching upward from start_i (wrapping)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NCH = 8,
  parameter int IW = clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  start_i,
  output logic [IW-1:0]  idx_o,
  output logic           vld_o
);
  logic [IW-1:0] j;
  // first set request at or after start_i, wrapping modulo NCH
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    j = '0;
    for (int k = 0; k < NCH; k++) begin
      j = IW'((int'(start_i) + k) % NCH);
      if (!vld_o && req_i[j]) begin
        idx_o = j;
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_vector_ctl.sv
// irq_vector_ctl: vectored interrupt controller; define IRQ_ROUND_ROBIN_EN for rotating priority
module irq_vector_ctl
  import irq_pkg::*;
#(
  parameter int              NCH      = 8,
  parameter logic [VEC_W-1:0] SPUR_VEC = 16'o000000,
  parameter int              BLANK    = 2
) (
  input  logic                 clk_p,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       irq_req,
  input  logic [VEC_W*NCH-1:0] irq_vec,
  output logic [NCH-1:0]       irq_ack,
  output logic                 virq,
  input  logic                 istb,
  output logic [VEC_W-1:0]     ivec,
  output logic                 iack
);
  localparam int IW = clog2(NCH);
  localparam int BW = clog2(BLANK + 1);
  irq_state_e       state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic             spur_q, spur_d;
  logic [VEC_W-1:0] ivec_q, ivec_d;
  logic             iack_q, iack_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic             virq_q;
  logic [BW-1:0]    blk_q [NCH];
  logic [NCH-1:0]   blanked, eff;
  logic [VEC_W-1:0] vec_a [NCH];
  logic [IW-1:0]    start, enc_idx;
  logic             enc_vld;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign blanked[i] = |blk_q[i];
    assign vec_a[i] = irq_vec[VEC_W*i +: VEC_W];
  end
  assign eff = irq_req & ~blanked;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
  assign ptr_d = (state_q == ACK && !spur_q) ? ((win_q == IW'(NCH - 1)) ? '0 : win_q + 1'b1) : ptr_q;
  // rotation pointer moves past the channel just served
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif
  irq_prio_enc #(.NCH(NCH), .IW(IW)) u_enc (
    .req_i  (eff),
    .start_i(start),
    .idx_o  (enc_idx),
    .vld_o  (enc_vld)
  );
  // strobe handshake: latch winner, present vector, acknowledge, wait for strobe release
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    spur_d = spur_q;
    ivec_d = ivec_q;
    iack_d = iack_q;
    ack_d = '0;
    case (state_q)
      IDLE: begin
        iack_d = 1'b0;
        if (istb) begin
          win_d = enc_idx;
          spur_d = ~enc_vld;
          state_d = SEL;
        end
      end
      SEL: begin
        ivec_d = spur_q ? SPUR_VEC : vec_a[win_q];
        state_d = istb ? ACK : IDLE;
      end
      ACK: begin
        iack_d = 1'b1;
        ack_d = spur_q ? '0 : NCH'(1) << win_q;
        state_d = WAIT;
      end
      default: begin
        iack_d = istb;
        state_d = istb ? WAIT : IDLE;
      end
    endcase
  end
  // FSM and registered outputs
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q <= '0;
      spur_q <= 1'b0;
      ivec_q <= '0;
      iack_q <= 1'b0;
      ack_q <= '0;
      virq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      spur_q <= spur_d;
      ivec_q <= ivec_d;
      iack_q <= iack_d;
      ack_q <= ack_d;
      virq_q <= |eff;
    end
  end
  // per-channel blanking so a device gets time to drop its request after service
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) blk_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) blk_q[i] <= ack_d[i] ? BW'(BLANK) : blk_q[i] - BW'(blanked[i]);
    end
  end
  assign irq_ack = ack_q;
  assign virq = virq_q;
  assign ivec = ivec_q;
  assign iack = iack_q;
endmodule
